sdram_port_arbiter: RTL



---
 rtl/sdram_port_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-port req/ack arbiter in front of a single SDRAM controller.
// Fixed priority video > ioctl > cpu, with a skip counter that forces a starved port in.
module sdram_port_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int MAX_SKIP = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    input  logic [DW/8-1:0] p0_be,
    output logic            p0_ack,
    output logic [DW-1:0]   p0_rdata,

    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    input  logic [DW/8-1:0] p1_be,
    output logic            p1_ack,
    output logic [DW-1:0]   p1_rdata,

    input  logic            p2_req,
    input  logic            p2_we,
    input  logic [AW-1:0]   p2_addr,
    input  logic [DW-1:0]   p2_wdata,
    input  logic [DW/8-1:0] p2_be,
    output logic            p2_ack,
    output logic [DW-1:0]   p2_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic            mem_done,
    input  logic [DW-1:0]   mem_rdata,

    output logic            busy,
    output logic [1:0]      grant
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_SKIP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t state;

    logic [2:0]          req;
    logic [2:0]          we;
    logic [AW-1:0]       addr  [3];
    logic [DW-1:0]       wdata [3];
    logic [BW-1:0]       be    [3];

    logic [SW-1:0]       skip  [3];
    logic [2:0]          ack_r;
    logic [DW-1:0]       rdata_r [3];

    logic [2:0]          forced;
    logic [1:0]          win;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;
    logic [BW-1:0]       sel_be;

    assign req      = {p2_req, p1_req, p0_req};
    assign we       = {p2_we, p1_we, p0_we};
    assign addr[0]  = p0_addr;
    assign addr[1]  = p1_addr;
    assign addr[2]  = p2_addr;
    assign wdata[0] = p0_wdata;
    assign wdata[1] = p1_wdata;
    assign wdata[2] = p2_wdata;
    assign be[0]    = p0_be;
    assign be[1]    = p1_be;
    assign be[2]    = p2_be;

    assign p0_ack   = ack_r[0];
    assign p1_ack   = ack_r[1];
    assign p2_ack   = ack_r[2];
    assign p0_rdata = rdata_r[0];
    assign p1_rdata = rdata_r[1];
    assign p2_rdata = rdata_r[2];

    // Starved ports (skip count at the bound) beat plain fixed priority.
    always_comb begin
        forced = '0;
        for (int unsigned i = 0; i < 3; i++)
            forced[i] = req[i] && (skip[i] == SW'(MAX_SKIP));
        if (forced[0])      win = 2'd0;
        else if (forced[1]) win = 2'd1;
        else if (forced[2]) win = 2'd2;
        else if (req[0])    win = 2'd0;
        else if (req[1])    win = 2'd1;
        else                win = 2'd2;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (win == 2'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i];
                sel_wdata = wdata[i];
                sel_be    = be[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            grant     <= 2'd3;
            ack_r     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                skip[i]    <= '0;
                rdata_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= win;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_be    <= sel_be;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (win == 2'(i))
                                skip[i] <= '0;
                            else if (req[i] && skip[i] != SW'(MAX_SKIP))
                                skip[i] <= skip[i] + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (mem_done) begin
                            state <= ACK;
                            for (int unsigned i = 0; i < 3; i++) begin
                                if (grant == 2'(i)) begin
                                    ack_r[i] <= 1'b1;
                                    if (!mem_we)
                                        rdata_r[i] <= mem_rdata;
                                end
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state <= ACK;
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (grant == 2'(i)) begin
                                ack_r[i] <= 1'b1;
                                if (!mem_we)
                                    rdata_r[i] <= mem_rdata;
                            end
                        end
                    end
                end
                ACK: begin
                    ack_r <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
